// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control unit.
// BRANCH_FULL_EN (used in instr_decode) enables the full conditional-branch set.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_IMM    = 7'd19;
  localparam logic [6:0] OP_AUIPC  = 7'd23;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_REG    = 7'd51;
  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_JAL    = 7'd111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  localparam logic [1:0] MT_WORD = 2'b00;
  localparam logic [1:0] MT_BYTE = 2'b01;
  localparam logic [1:0] MT_HALF = 2'b10;

  localparam logic [1:0] SRCA_RS1  = 2'd0;
  localparam logic [1:0] SRCA_PC   = 2'd1;
  localparam logic [1:0] SRCA_ZERO = 2'd2;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic       legal;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jump;
    logic       taken;
    logic [3:0] alu_ctrl;
    logic [2:0] imm_src;
    logic [1:0] res_src;
    logic [1:0] mem_type;
    logic       mem_sign;
    logic [1:0] src_a;
    logic       src_b;
  } decode_t;

  // alt is funct7[5]; it only turns add into sub when allow_sub is set.
  function automatic logic [3:0] alu_op(input logic [2:0] funct3, input logic alt,
                                        input logic allow_sub);
    case (funct3)
      3'b000:  alu_op = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decode for mc_controlunit.
// BRANCH_FULL_EN: all six conditional branches; otherwise only beq is legal.
module instr_decode
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       neg,
  input  logic       carry,
  output decode_t    dec
);

  // NOTE: every field gets a default before the case so no path leaves a latch.
  always_comb begin
    dec          = '0;
    dec.mem_type = (funct3[1:0] == 2'b00) ? MT_BYTE :
                   (funct3[1:0] == 2'b01) ? MT_HALF : MT_WORD;
    dec.mem_sign = (funct3 == 3'b100) || (funct3 == 3'b101);
    case (opcode)
      OP_LOAD:  begin dec.legal = 1'b1; dec.is_load = 1'b1; dec.imm_src = IMM_I;
                      dec.res_src = RES_LOAD; dec.src_b = 1'b1; end
      OP_IMM:   begin dec.legal = 1'b1; dec.alu_ctrl = alu_op(funct3, funct7_5, 1'b0);
                      dec.imm_src = IMM_I; dec.src_b = 1'b1; end
      OP_AUIPC: begin dec.legal = 1'b1; dec.imm_src = IMM_U; dec.src_a = SRCA_PC;
                      dec.src_b = 1'b1; end
      OP_STORE: begin dec.legal = 1'b1; dec.is_store = 1'b1; dec.imm_src = IMM_S;
                      dec.src_b = 1'b1; end
      OP_REG:   begin dec.legal = 1'b1; dec.alu_ctrl = alu_op(funct3, funct7_5, 1'b1); end
      OP_LUI:   begin dec.legal = 1'b1; dec.imm_src = IMM_U; dec.src_a = SRCA_ZERO;
                      dec.src_b = 1'b1; end
      OP_JALR:  begin dec.legal = 1'b1; dec.is_jump = 1'b1; dec.imm_src = IMM_I;
                      dec.res_src = RES_PC4; dec.src_b = 1'b1; end
      OP_JAL:   begin dec.legal = 1'b1; dec.is_jump = 1'b1; dec.imm_src = IMM_J;
                      dec.res_src = RES_PC4; dec.src_b = 1'b1; end
      OP_BRANCH: begin
        dec.is_branch = 1'b1;
        dec.alu_ctrl  = ALU_SUB;
        dec.imm_src   = IMM_B;
`ifdef BRANCH_FULL_EN
        dec.legal = (funct3[2:1] != 2'b01);
        case (funct3)
          3'b000:  dec.taken = zero;
          3'b001:  dec.taken = !zero;
          3'b100:  dec.taken = neg;
          3'b101:  dec.taken = !neg;
          3'b110:  dec.taken = !carry;   // carry set means no borrow, i.e. rs1 >= rs2
          3'b111:  dec.taken = carry;
          default: dec.taken = 1'b0;
        endcase
`else
        dec.legal = (funct3 == 3'b000);
        dec.taken = zero;
`endif
      end
      default: dec = dec;
    endcase
  end

`ifndef BRANCH_FULL_EN
  logic unused_flags;
  assign unused_flags = neg ^ carry;
`endif

endmodule

// File: rtl/mc_controlunit.sv
// Multi-cycle RISC-V style control unit: FSM, instruction register, retired counter.
// Optional BRANCH_FULL_EN widens the branch set (see instr_decode).
module mc_controlunit
  import mc_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] Instr_i,
  input  logic                  MemReady_i,
  input  logic                  Zero_i,
  input  logic                  Neg_i,
  input  logic                  Carry_i,
  output logic                  MemReq_o,
  output logic                  MemWrite_o,
  output logic                  IRWrite_o,
  output logic                  PCWrite_o,
  output logic                  RegWrite_o,
  output logic [3:0]            ALUCtrl_o,
  output logic [2:0]            ImmSrc_o,
  output logic [1:0]            ResultSrc_o,
  output logic [1:0]            MemType_o,
  output logic                  MemSign_o,
  output logic [1:0]            ALUSrcA_o,
  output logic                  ALUSrcB_o,
  output logic                  PCSrc_o,
  output logic [2:0]            State_o,
  output logic                  Illegal_o,
  output logic [CNT_WIDTH-1:0]  Instret_o
);

  state_t                state;
  logic [DATA_WIDTH-1:0] ir;
  logic [CNT_WIDTH-1:0]  instret;
  decode_t               dec;

  instr_decode u_decode (
    .opcode   (ir[6:0]),
    .funct3   (ir[14:12]),
    .funct7_5 (ir[30]),
    .zero     (Zero_i),
    .neg      (Neg_i),
    .carry    (Carry_i),
    .dec      (dec)
  );

  logic unused_ir;
  assign unused_ir = ^{ir[DATA_WIDTH-1:31], ir[29:15], ir[11:7]};

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= S_FETCH;
      ir      <= DATA_WIDTH'(NOP_INSTR);
      instret <= '0;
    end else begin
      case (state)
        S_FETCH: if (MemReady_i) begin
          ir    <= Instr_i;
          state <= S_DECODE;
        end
        S_DECODE: state <= dec.legal ? S_EXEC : S_TRAP;
        S_EXEC: begin
          if (dec.is_load || dec.is_store) begin
            state <= S_MEM;
          end else if (dec.is_branch) begin
            state   <= S_FETCH;
            instret <= instret + CNT_WIDTH'(1);
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: if (MemReady_i) begin
          if (dec.is_store) begin
            state   <= S_FETCH;
            instret <= instret + CNT_WIDTH'(1);
          end else begin
            state <= S_WB;
          end
        end
        S_WB: begin
          state   <= S_FETCH;
          instret <= instret + CNT_WIDTH'(1);
        end
        S_TRAP:  state <= S_TRAP;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Strobes are masked during reset so a coincident MemReady_i has no effect.
  always_comb begin
    MemReq_o   = 1'b0;
    MemWrite_o = 1'b0;
    IRWrite_o  = 1'b0;
    PCWrite_o  = 1'b0;
    PCSrc_o    = 1'b0;
    RegWrite_o = 1'b0;
    if (!rst_i) begin
      case (state)
        S_FETCH: begin
          MemReq_o  = 1'b1;
          IRWrite_o = MemReady_i;
          PCWrite_o = MemReady_i;
        end
        S_EXEC: begin
          PCWrite_o = dec.is_jump || (dec.is_branch && dec.taken);
          PCSrc_o   = dec.is_jump || (dec.is_branch && dec.taken);
        end
        S_MEM: begin
          MemReq_o   = 1'b1;
          MemWrite_o = dec.is_store;
        end
        S_WB:    RegWrite_o = 1'b1;
        default: MemReq_o = 1'b0;
      endcase
    end
  end

  assign ALUCtrl_o   = dec.alu_ctrl;
  assign ImmSrc_o    = dec.imm_src;
  assign ResultSrc_o = dec.res_src;
  assign MemType_o   = dec.mem_type;
  assign MemSign_o   = dec.mem_sign;
  assign ALUSrcA_o   = dec.src_a;
  assign ALUSrcB_o   = dec.src_b;
  assign State_o     = state;
  assign Illegal_o   = (state == S_TRAP);
  assign Instret_o   = instret;

endmodule
